visual_mem_ctrl: RTL and testbench

//  Parametrised CPU data-memory router with a buffered VRAM path. Decodes each CPU access
//  to general RAM or display VRAM. RAM is accessed directly with a registered read.

---
 rtl/visual_mem_ctrl_if.sv | 32 +++
 rtl/visual_mem_ctrl.sv | 171 +++++++++++++++++
 tb/tb_visual_mem_ctrl.sv | 307 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/visual_mem_ctrl_if.sv
// CPU data-port and display-port signal bundle for visual_mem_ctrl.
// master = processor/display side, slave = controller side.
interface visual_mem_ctrl_if #(
    parameter int DATA_W     = 32,
    parameter int VRAM_WORDS = 700
);
    localparam int DISP_AW = $clog2(VRAM_WORDS);

    logic               we;
    logic               re;
    logic [31:0]        a;
    logic [DATA_W-1:0]  wd;
    logic [DATA_W-1:0]  rd;
    logic               rd_valid;
    logic               stall;
    logic               addr_err;
    logic               disp_re;
    logic [DISP_AW-1:0] disp_addr;
    logic [DATA_W-1:0]  disp_data;
    logic               dirty;
    logic               disp_ack;

    modport master (
        output we, re, a, wd, disp_re, disp_addr, disp_ack,
        input  rd, rd_valid, stall, addr_err, disp_data, dirty
    );

    modport slave (
        input  we, re, a, wd, disp_re, disp_addr, disp_ack,
        output rd, rd_valid, stall, addr_err, disp_data, dirty
    );
endinterface

// File: rtl/visual_mem_ctrl.sv
// CPU data-memory router: direct RAM plus FIFO-buffered VRAM with display-port priority.
// Define VISUAL_MEM_READBACK_EN to let CPU reads return VRAM contents (otherwise they read 0).
module visual_mem_ctrl #(
    parameter int DATA_W     = 32,
    parameter int RAM_WORDS  = 4096,
    parameter int VRAM_WORDS = 700,
    parameter int SEL_BIT    = 14,
    parameter int FIFO_DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    visual_mem_ctrl_if.slave bus
);
    localparam int RAM_AW  = $clog2(RAM_WORDS);
    localparam int VRAM_AW = $clog2(VRAM_WORDS);
    localparam int PTR_W   = $clog2(FIFO_DEPTH);
    localparam int CNT_W   = PTR_W + 1;
    localparam int ENT_W   = VRAM_AW + DATA_W;

    logic [DATA_W-1:0] ram_mem  [RAM_WORDS];
    logic [DATA_W-1:0] vram_mem [VRAM_WORDS];
    logic [ENT_W-1:0]  fifo_mem [FIFO_DEPTH];

    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [DATA_W-1:0] rd_q, rd_d;
    logic [DATA_W-1:0] disp_data_q, disp_data_d;
    logic              rd_valid_q, rd_valid_d;
    logic              addr_err_q, addr_err_d;
    logic              dirty_q, dirty_d;
    logic              drain_q, drain_d;

    logic [31:0]        idx_ext;
    logic [RAM_AW-1:0]  ram_idx;
    logic [VRAM_AW-1:0] vram_idx;
    logic [VRAM_AW-1:0] head_idx;
    logic [DATA_W-1:0]  head_data;
    logic               sel_vram;
    logic               in_range;
    logic               wr_req;
    logic               rd_req;
    logic               fifo_full;
    logic               fifo_empty;
    logic               stall;
    logic               accept;
    logic               ram_wr;
    logic               push;
    logic               pop;
    logic               unused_addr_bits;

    assign idx_ext          = 32'(bus.a[SEL_BIT-1:2]);
    assign ram_idx          = idx_ext[RAM_AW-1:0];
    assign vram_idx         = idx_ext[VRAM_AW-1:0];
    assign unused_addr_bits = ^{bus.a[31:SEL_BIT+1], bus.a[1:0], idx_ext};
    assign {head_idx, head_data} = fifo_mem[rd_ptr_q];

    // Address decode, acceptance and FIFO push/pop qualification
    always_comb begin
        sel_vram   = bus.a[SEL_BIT];
        wr_req     = bus.we;
        rd_req     = bus.re & ~bus.we;
        in_range   = sel_vram ? (idx_ext < 32'(VRAM_WORDS)) : (idx_ext < 32'(RAM_WORDS));
        fifo_full  = (count_q == CNT_W'(FIFO_DEPTH));
        fifo_empty = (count_q == '0);
        stall      = wr_req & sel_vram & fifo_full;
`ifdef VISUAL_MEM_READBACK_EN
        // Readback must see every queued write, and the scanner owns the VRAM port.
        if (rd_req && sel_vram && (!fifo_empty || bus.disp_re)) begin
            stall = 1'b1;
        end
`endif
        accept = ~stall;
        ram_wr = accept & wr_req & ~sel_vram & in_range;
        push   = accept & wr_req & sel_vram & in_range;
        pop    = ~bus.disp_re & ~fifo_empty;
    end

    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        rd_d        = rd_q;
        disp_data_d = disp_data_q;
        rd_valid_d  = accept & rd_req;
        addr_err_d  = accept & (wr_req | rd_req) & ~in_range;
        drain_d     = pop;
        dirty_d     = dirty_q;

        if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase

        if (rd_valid_d) begin
            if (!in_range) begin
                rd_d = '0;
            end else if (!sel_vram) begin
                rd_d = ram_mem[ram_idx];
            end else begin
`ifdef VISUAL_MEM_READBACK_EN
                rd_d = vram_mem[vram_idx];
`else
                rd_d = '0;
`endif
            end
        end

        if (bus.disp_re) begin
            disp_data_d = (32'(bus.disp_addr) < 32'(VRAM_WORDS)) ? vram_mem[bus.disp_addr] : '0;
        end

        // A drain committed last edge marks the frame dirty even if acked now.
        if (drain_q) begin
            dirty_d = 1'b1;
        end else if (bus.disp_ack) begin
            dirty_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            rd_q        <= '0;
            disp_data_q <= '0;
            rd_valid_q  <= 1'b0;
            addr_err_q  <= 1'b0;
            dirty_q     <= 1'b0;
            drain_q     <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            rd_q        <= rd_d;
            disp_data_q <= disp_data_d;
            rd_valid_q  <= rd_valid_d;
            addr_err_q  <= addr_err_d;
            dirty_q     <= dirty_d;
            drain_q     <= drain_d;
        end
    end

    // Storage arrays are not reset; an emptied FIFO (count 0) can never pop stale entries.
    always_ff @(posedge clk) begin
        if (ram_wr) begin
            ram_mem[ram_idx] <= bus.wd;
        end
        if (push) begin
            fifo_mem[wr_ptr_q] <= {vram_idx, bus.wd};
        end
        if (pop) begin
            vram_mem[head_idx] <= head_data;
        end
    end

    assign bus.rd        = rd_q;
    assign bus.rd_valid  = rd_valid_q;
    assign bus.stall     = stall;
    assign bus.addr_err  = addr_err_q;
    assign bus.disp_data = disp_data_q;
    assign bus.dirty     = dirty_q;
endmodule

// File: tb/tb_visual_mem_ctrl.sv
// Self-checking bench for visual_mem_ctrl: directed scenarios plus randomized traffic
// compared every cycle against a queue/array model of the memory router.
module tb_visual_mem_ctrl;
    localparam int FD = 4;

    logic clk;
    logic rst;
    int   n_chk;
    int   n_fail;

    visual_mem_ctrl_if #(.DATA_W(32), .VRAM_WORDS(700)) bus ();

    visual_mem_ctrl dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Behavioural model state
    typedef struct {
        int          idx;
        logic [31:0] d;
    } ent_t;

    logic [31:0] ram_m  [4096];
    bit          ram_k  [4096];
    logic [31:0] vram_m [700];
    bit          vram_k [700];
    ent_t        fifo_m [$];
    logic [31:0] m_rd;
    bit          m_rd_k;
    logic        m_rd_valid;
    logic        m_addr_err;
    logic        m_dirty;
    logic        m_set_pend;
    logic [31:0] m_dd;
    bit          m_dd_k;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        fifo_m.delete();
        m_rd       = '0;
        m_rd_k     = 1'b1;
        m_rd_valid = 1'b0;
        m_addr_err = 1'b0;
        m_dirty    = 1'b0;
        m_set_pend = 1'b0;
        m_dd       = '0;
        m_dd_k     = 1'b1;
    endtask

    function automatic logic f_stall();
        logic sel;
        logic rdq;
        sel = bus.a[14];
        rdq = bus.re && !bus.we;
        if (bus.we && sel && fifo_m.size() == FD) return 1'b1;
`ifdef VISUAL_MEM_READBACK_EN
        if (rdq && sel && (fifo_m.size() != 0 || bus.disp_re)) return 1'b1;
`endif
        return 1'b0;
    endfunction

    task automatic model_step(input logic stalled);
        int   idx;
        logic sel;
        logic inr;
        ent_t e;
        idx = int'(bus.a[13:2]);
        sel = bus.a[14];
        inr = sel ? (idx < 700) : (idx < 4096);

        m_dirty    = m_set_pend ? 1'b1 : (bus.disp_ack ? 1'b0 : m_dirty);
        m_set_pend = 1'b0;

        if (bus.disp_re) begin
            m_dd   = vram_m[int'(bus.disp_addr)];
            m_dd_k = vram_k[int'(bus.disp_addr)];
        end else if (fifo_m.size() > 0) begin
            e = fifo_m.pop_front();
            vram_m[e.idx] = e.d;
            vram_k[e.idx] = 1'b1;
            m_set_pend    = 1'b1;
        end

        m_rd_valid = 1'b0;
        m_addr_err = 1'b0;
        if (!stalled) begin
            if (bus.we) begin
                if (!inr) begin
                    m_addr_err = 1'b1;
                end else if (sel) begin
                    e.idx = idx;
                    e.d   = bus.wd;
                    fifo_m.push_back(e);
                end else begin
                    ram_m[idx] = bus.wd;
                    ram_k[idx] = 1'b1;
                end
            end else if (bus.re) begin
                m_rd_valid = 1'b1;
                m_addr_err = !inr;
                if (!inr) begin
                    m_rd = '0; m_rd_k = 1'b1;
                end else if (!sel) begin
                    m_rd = ram_m[idx]; m_rd_k = ram_k[idx];
                end else begin
`ifdef VISUAL_MEM_READBACK_EN
                    m_rd = vram_m[idx]; m_rd_k = vram_k[idx];
`else
                    m_rd = '0; m_rd_k = 1'b1;
`endif
                end
            end
        end
    endtask

    // Per-cycle compare against the model, mid-cycle away from the active edge
    always @(negedge clk) begin : cmp
        logic s;
        if (rst) model_reset();
        s = rst ? 1'b0 : f_stall();
        chk("stall", {31'b0, bus.stall}, {31'b0, s});
        chk("rd_valid", {31'b0, bus.rd_valid}, {31'b0, m_rd_valid});
        if (m_rd_valid && m_rd_k) chk("rd", bus.rd, m_rd);
        chk("addr_err", {31'b0, bus.addr_err}, {31'b0, m_addr_err});
        chk("dirty", {31'b0, bus.dirty}, {31'b0, m_dirty});
        if (m_dd_k) chk("disp_data", bus.disp_data, m_dd);
        if (!rst) model_step(s);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.we       = 1'b0;
        bus.re       = 1'b0;
        bus.disp_re  = 1'b0;
        bus.disp_ack = 1'b0;
    endtask

    task automatic cpu_wr(input logic [31:0] addr, input logic [31:0] data);
        bus.we = 1'b1; bus.re = 1'b0; bus.a = addr; bus.wd = data;
    endtask

    task automatic cpu_rd(input logic [31:0] addr);
        bus.we = 1'b0; bus.re = 1'b1; bus.a = addr;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin : stim
        logic        hold;
        logic [31:0] r;
        int          idx;
        logic        sel;
        n_chk  = 0;
        n_fail = 0;
        rst    = 1'b0;
        idle();
        bus.a = '0; bus.wd = '0; bus.disp_addr = '0;
        #2 rst = 1'b1;
        tick(); tick();
        chk("rst_rd", bus.rd, 32'h0);
        chk("rst_rd_valid", {31'b0, bus.rd_valid}, 32'h0);
        chk("rst_stall", {31'b0, bus.stall}, 32'h0);
        chk("rst_dirty", {31'b0, bus.dirty}, 32'h0);
        chk("rst_disp_data", bus.disp_data, 32'h0);
        rst = 1'b0;
        tick();

        // RAM write then read
        cpu_wr(32'h0000_0010, 32'hDEAD_BEEF); tick();
        cpu_rd(32'h0000_0010); tick();
        chk("t1_rd_valid", {31'b0, bus.rd_valid}, 32'h1);
        chk("t1_rd", bus.rd, 32'hDEAD_BEEF);
        idle(); tick();
        chk("t1_rd_valid_drop", {31'b0, bus.rd_valid}, 32'h0);

        // VRAM buffering with display priority, then drain
        bus.disp_re = 1'b1; bus.disp_addr = 10'd0;
        for (int i = 0; i < 4; i++) begin
            cpu_wr(32'h4000 + 32'(4 * i), 32'h100 + 32'(i)); tick();
        end
        cpu_wr(32'h4010, 32'h104); #2;
        chk("t2_stall_full", {31'b0, bus.stall}, 32'h1);
        tick();
        bus.disp_re = 1'b0; #2;
        chk("t2_stall_pop_same_cycle", {31'b0, bus.stall}, 32'h1);
        tick(); #2;
        chk("t2_stall_release", {31'b0, bus.stall}, 32'h0);
        tick(); idle(); ticks(6);
        chk("t2_dirty", {31'b0, bus.dirty}, 32'h1);
        bus.disp_re = 1'b1;
        bus.disp_addr = 10'd0; tick(); chk("t2_vram0", bus.disp_data, 32'h100);
        bus.disp_addr = 10'd2; tick(); chk("t2_vram2", bus.disp_data, 32'h102);
        bus.disp_addr = 10'd4; tick(); chk("t2_vram4", bus.disp_data, 32'h104);

        // Display priority blocks draining
        bus.disp_addr = 10'd3;
        for (int i = 0; i < 4; i++) begin
            cpu_wr(32'h4000 + 32'(4 * (20 + i)), 32'h200 + 32'(i)); tick();
        end
        chk("t3_disp_hold", bus.disp_data, 32'h103);
        cpu_wr(32'h4000 + 32'(4 * 24), 32'h204); ticks(3); #2;
        chk("t3_no_drain", {31'b0, bus.stall}, 32'h1);
        idle(); ticks(6);
        bus.disp_re = 1'b1; bus.disp_addr = 10'd23; tick();
        chk("t3_vram23", bus.disp_data, 32'h203);
        idle();

        // Out-of-range and write/read collision
        cpu_wr(32'h4AF0, 32'hBAD0_BAD0); tick();
        chk("t4_addr_err", {31'b0, bus.addr_err}, 32'h1);
        idle(); tick();
        chk("t4_addr_err_pulse", {31'b0, bus.addr_err}, 32'h0);
        chk("t4_no_fifo", {31'b0, bus.dirty}, 32'h1);
        cpu_rd(32'h4AF0); tick();
        chk("t4_oor_rd_valid", {31'b0, bus.rd_valid}, 32'h1);
        chk("t4_oor_rd", bus.rd, 32'h0);
        bus.we = 1'b1; bus.re = 1'b1; bus.a = 32'h20; bus.wd = 32'h55; tick();
        chk("t4_collide_no_rd", {31'b0, bus.rd_valid}, 32'h0);
        cpu_rd(32'h20); tick();
        chk("t4_collide_wr", bus.rd, 32'h55);
        idle();

        // dirty set/ack race
        bus.disp_ack = 1'b1; tick();
        chk("t5_ack_clear", {31'b0, bus.dirty}, 32'h0);
        bus.disp_ack = 1'b0;
        cpu_wr(32'h4000 + 32'(4 * 30), 32'h555); tick();
        idle(); tick();
        chk("t5_not_yet", {31'b0, bus.dirty}, 32'h0);
        bus.disp_ack = 1'b1; tick();
        chk("t5_set_wins", {31'b0, bus.dirty}, 32'h1);
        tick();
        chk("t5_ack_alone", {31'b0, bus.dirty}, 32'h0);
        idle();

        // Reset discards queued writes
        for (int i = 0; i < 3; i++) begin
            cpu_wr(32'h4000 + 32'(4 * (10 + i)), 32'h300 + 32'(i)); tick();
        end
        idle(); ticks(5);
        bus.disp_re = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cpu_wr(32'h4000 + 32'(4 * (10 + i)), 32'h400 + 32'(i)); tick();
        end
        bus.we = 1'b0; rst = 1'b1; #2;
        chk("t6_rst_stall", {31'b0, bus.stall}, 32'h0);
        chk("t6_rst_dirty", {31'b0, bus.dirty}, 32'h0);
        chk("t6_rst_disp_data", bus.disp_data, 32'h0);
        tick(); rst = 1'b0; bus.disp_re = 1'b0; ticks(5);
        chk("t6_dirty_stays", {31'b0, bus.dirty}, 32'h0);
        bus.disp_re = 1'b1;
        bus.disp_addr = 10'd10; tick(); chk("t6_vram10", bus.disp_data, 32'h300);
        bus.disp_addr = 10'd12; tick(); chk("t6_vram12", bus.disp_data, 32'h302);
        idle();

        // Randomized traffic
        hold = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            if (c % 700 == 699) begin
                bus.we = 1'b0; bus.re = 1'b0; rst = 1'b1;
                tick();
                rst = 1'b0; hold = 1'b0;
                continue;
            end
            if (!hold) begin
                r   = $urandom();
                sel = ($urandom_range(0, 1) == 1);
                idx = ($urandom_range(0, 19) == 0) ? 698 + int'($urandom_range(0, 5))
                                                  : int'($urandom_range(0, 15));
                bus.we = ($urandom_range(0, 99) < 35);
                bus.re = ($urandom_range(0, 99) < 35);
                bus.a  = (r & 32'hFFFF_8003) | (32'(sel) << 14) | (32'(idx) << 2);
                bus.wd = $urandom();
            end
            bus.disp_re   = ($urandom_range(0, 99) < 30);
            bus.disp_addr = 10'($urandom_range(0, 15));
            bus.disp_ack  = ($urandom_range(0, 99) < 10);
            #2;
            hold = bus.stall;
            tick();
        end
        idle(); ticks(8);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
